ex_writeback: RTL

- Stage directly downstream of the execute stage (preprocessor + ALU).
- Tracks the destination tag of every issued instruction through the fixed execute latency and aligns it with aluout/carry.
- Drives a registered register-file write port and the carry flag.
- Buffers execute-stage stores in a small FIFO and hands them to data memory over a valid/ready handshake, with back-pressure to issue.

---
 rtl/ex_writeback.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ex_writeback.sv
// Writeback stage behind execute. It carries destination tags through the fixed execute
// latency into a registered register-file write port. It also runs a store FIFO toward data memory.
module ex_writeback #(
  parameter int unsigned REG_WD     = 16,
  parameter int unsigned ADDR_WD    = 16,
  parameter int unsigned RF_ADDR_WD = 3,
  parameter int unsigned EX_LATENCY = 2,
  parameter int unsigned SQ_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable_ex,
  input  logic                        wb_en_in,
  input  logic [RF_ADDR_WD-1:0]       dest_in,
  input  logic [REG_WD-1:0]           aluout,
  input  logic                        carry,
  input  logic                        mem_write_en,
  input  logic [REG_WD-1:0]           mem_data_write_out,
  input  logic [ADDR_WD-1:0]          mem_addr_in,
  output logic                        rf_we,
  output logic [RF_ADDR_WD-1:0]       rf_waddr,
  output logic [REG_WD-1:0]           rf_wdata,
  output logic                        carry_flag,
  output logic                        st_valid,
  output logic [ADDR_WD-1:0]          st_addr,
  output logic [REG_WD-1:0]           st_data,
  input  logic                        st_ready,
  output logic [$clog2(SQ_DEPTH):0]   sq_count,
  output logic                        stall,
  output logic                        sq_overflow
);

  localparam int unsigned PtrW = $clog2(SQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Tag pipe: valid bits reset, destination fields are don't-care when invalid
  logic [EX_LATENCY-1:0] tag_v_q;
  logic [RF_ADDR_WD-1:0] tag_dest_q [EX_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0] <= enable_ex & wb_en_in;
      for (int i = EX_LATENCY - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    tag_dest_q[0] <= dest_in;
    for (int i = EX_LATENCY - 1; i > 0; i--) begin
      tag_dest_q[i] <= tag_dest_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      carry_flag <= 1'b0;
    end else if (tag_v_q[EX_LATENCY-1]) begin
      rf_we      <= 1'b1;
      rf_waddr   <= tag_dest_q[EX_LATENCY-1];
      rf_wdata   <= aluout;
      carry_flag <= carry;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Store queue
  logic [ADDR_WD-1:0] sq_addr_q [SQ_DEPTH];
  logic [REG_WD-1:0]  sq_data_q [SQ_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               ovf_q;
  logic               full, push, pop;

  assign full     = (count_q == CntW'(SQ_DEPTH));
  assign st_valid = (count_q != '0);
  assign pop      = st_valid & st_ready;
  // A pop on the same edge frees a slot, so a full queue still accepts
  assign push     = mem_write_en & (~full | pop);
  assign st_addr  = sq_addr_q[rd_ptr_q];
  assign st_data  = sq_data_q[rd_ptr_q];
  assign sq_count = count_q;
  assign stall    = (count_q >= CntW'(SQ_DEPTH - 1));
  assign sq_overflow = ovf_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (mem_write_en && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      sq_addr_q[wr_ptr_q] <= mem_addr_in;
      sq_data_q[wr_ptr_q] <= mem_data_write_out;
    end
  end

endmodule
